// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types and limits for the bit-serial add sequencer.
package serial_add_pkg;

  localparam int MIN_WIDTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/serial_add_shreg.sv
// serial_add_shreg: load / shift-right operand register with LSB tap.
module serial_add_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             lsb
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {1'b0, q[WIDTH-1:1]};
    end
  end

  assign lsb = q[0];

endmodule

// File: rtl/serial_add_seq.sv
// serial_add_seq: feeds an external registered full-adder cell LSB-first.
// Optional subtraction is enabled with `define SERIAL_ADD_SUB_EN.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_bit_a,
  output logic             o_bit_b,
  output logic             o_bit_c,
  input  logic             i_sum_bit,
  input  logic             i_carry_bit,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < MIN_WIDTH) begin : g_bad_width
    $error("serial_add_seq: WIDTH too small");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             cin_q;
  logic             c_msb;
  logic [WIDTH-2:0] acc;
  logic             a_lsb;
  logic             b_lsb;
  logic             accept;
  logic             run;
  logic             shift;
  logic [WIDTH-1:0] b_load;
  logic             cin_load;

`ifdef SERIAL_ADD_SUB_EN
  assign b_load   = i_sub ? ~i_b : i_b;
  assign cin_load = i_sub | i_cin;
`else
  logic unused_sub;
  assign unused_sub = i_sub;
  assign b_load     = i_b;
  assign cin_load   = i_cin;
`endif

  assign o_ready = (state == IDLE);
  assign o_valid = (state == DONE);
  assign accept  = o_ready & i_valid;
  assign run     = (state == RUN);
  assign shift   = run & (cnt != LAST);

  serial_add_shreg #(.WIDTH(WIDTH)) u_sh_a (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .load  (accept),
    .shift (shift),
    .din   (i_a),
    .lsb   (a_lsb)
  );

  serial_add_shreg #(.WIDTH(WIDTH)) u_sh_b (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .load  (accept),
    .shift (shift),
    .din   (b_load),
    .lsb   (b_lsb)
  );

  // Bit 0 uses the latched carry-in, so the cell's reset value never matters.
  assign o_bit_a = run & a_lsb;
  assign o_bit_b = run & b_lsb;
  assign o_bit_c = run & ((cnt == '0) ? cin_q : i_carry_bit);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      cin_q  <= 1'b0;
      c_msb  <= 1'b0;
      acc    <= '0;
      o_sum  <= '0;
      o_cout <= 1'b0;
      o_ovf  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_valid) begin
            cin_q <= cin_load;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (cnt != '0) begin
            acc[cnt - 1'b1] <= i_sum_bit;
          end
          if (cnt == LAST) begin
            c_msb <= o_bit_c;
            state <= DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          o_sum  <= {i_sum_bit, acc};
          o_cout <= i_carry_bit;
          o_ovf  <= c_msb ^ i_carry_bit;
          state  <= DONE;
        end
        DONE: begin
          if (i_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: sequencer with a registered full-adder cell in the loop,
// checked against an arithmetic reference model.
module tb_serial_add_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_cin = 1'b0;
  logic         i_sub = 1'b0;
  logic         i_ready = 1'b0;
  logic [W-1:0] i_a = '0;
  logic [W-1:0] i_b = '0;
  logic         o_ready;
  logic         bit_a;
  logic         bit_b;
  logic         bit_c;
  logic         o_valid;
  logic [W-1:0] o_sum;
  logic         o_cout;
  logic         o_ovf;
  logic         cell_sum = 1'b0;
  logic         cell_carry = 1'b0;

  int checks = 0;
  int errors = 0;

  serial_add_seq #(.WIDTH(W)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_a         (i_a),
    .i_b         (i_b),
    .i_cin       (i_cin),
    .i_sub       (i_sub),
    .o_bit_a     (bit_a),
    .o_bit_b     (bit_b),
    .o_bit_c     (bit_c),
    .i_sum_bit   (cell_sum),
    .i_carry_bit (cell_carry),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_sum       (o_sum),
    .o_cout      (o_cout),
    .o_ovf       (o_ovf)
  );

  // Registered 1-bit full-adder cell, no reset.
  always @(posedge clk) begin
    cell_sum   <= bit_a ^ bit_b ^ bit_c;
    cell_carry <= (bit_a & bit_b) | (bit_a & bit_c) | (bit_b & bit_c);
  end

  always #5 clk = ~clk;

  // Returns {ovf, cout, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic cin,
                                         input logic sub);
    logic [W-1:0] bb;
    logic         c;
    logic [W:0]   full;
    logic [W-1:0] s;
    bb = b;
    c  = cin;
`ifdef SERIAL_ADD_SUB_EN
    if (sub) begin
      bb = ~b;
      c  = 1'b1;
    end
`else
    c = cin | (sub & 1'b0);
`endif
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
    s = full[W-1:0];
    return {(a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]), full[W], s};
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!o_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!o_ready) begin
      errors++;
      $display("FAIL wait_ready: o_ready=%b required 1", o_ready);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub,
                        output logic [W+1:0] res, output int lat);
    wait_ready();
    i_a = a;
    i_b = b;
    i_cin = cin;
    i_sub = sub;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = {o_ovf, o_cout, o_sum};
  endtask

  task automatic finish_op();
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({o_ready, o_valid, o_sum, o_cout, o_ovf, bit_a, bit_b, bit_c} !==
        {1'b1, 1'b0, 8'h00, 5'b0}) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b sum=%h co=%b ov=%b bits=%b%b%b",
               o_ready, o_valid, o_sum, o_cout, o_ovf, bit_a, bit_b, bit_c);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [5] = '{8'h35, 8'hFF, 8'h00, 8'h7F, 8'h80};
    logic [W-1:0] tb [5] = '{8'h4A, 8'h01, 8'h00, 8'h01, 8'h80};
    logic         tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [W+1:0] te [5] = '{{2'b00, 8'h7F}, {2'b01, 8'h00}, {2'b00, 8'h01},
                             {2'b10, 8'h80}, {2'b11, 8'h00}};
    logic [W+1:0] res;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], tc[i], 1'b0, res, lat);
      checks++;
      if (res !== te[i]) begin
        errors++;
        $display("FAIL directed_%0d: got {ovf,co,sum}=%h required %h",
                 i, res, te[i]);
      end
      checks++;
      if (lat != 9) begin
        errors++;
        $display("FAIL latency_%0d: got %0d required 9", i, lat);
      end
      finish_op();
      checks++;
      if (!o_ready || o_valid) begin
        errors++;
        $display("FAIL handshake_%0d: rdy=%b vld=%b required 1 0",
                 i, o_ready, o_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W+1:0] res;
    logic [W+1:0] exp;
    int lat;
    a = W'($urandom);
    b = W'($urandom);
    run_op(a, b, 1'b0, 1'b0, res, lat);
    exp = model(a, b, 1'b0, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if (!o_valid || o_ready || {o_ovf, o_cout, o_sum} !== res) begin
        errors++;
        $display("FAIL bp_hold: vld=%b rdy=%b out=%h required 1 0 %h",
                 o_valid, o_ready, {o_ovf, o_cout, o_sum}, res);
      end
    end
    checks++;
    if (res !== exp) begin
      errors++;
      $display("FAIL bp_result: got %h required %h", res, exp);
    end
    finish_op();
    checks++;
    if (!o_ready || o_valid) begin
      errors++;
      $display("FAIL bp_release: rdy=%b vld=%b required 1 0", o_ready, o_valid);
    end
    a = W'($urandom);
    b = W'($urandom);
    exp = model(a, b, 1'b1, 1'b0);
    i_a = a;
    i_b = b;
    i_cin = 1'b1;
    i_sub = 1'b0;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    checks++;
    if (o_ready) begin
      errors++;
      $display("FAIL bp_reaccept: rdy=%b required 0", o_ready);
    end
    lat = 0;
    while (!o_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if ({o_ovf, o_cout, o_sum} !== exp || lat != 9) begin
      errors++;
      $display("FAIL bp_next: got %h lat %0d required %h lat 9",
               {o_ovf, o_cout, o_sum}, lat, exp);
    end
    finish_op();
  endtask

  task automatic test_reset_mid();
    logic [W+1:0] res;
    int lat;
    wait_ready();
    i_a = 8'hAA;
    i_b = 8'h55;
    i_cin = 1'b1;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_ready, o_valid, o_sum, o_cout, o_ovf, bit_a, bit_b, bit_c} !==
        {1'b1, 1'b0, 8'h00, 5'b0}) begin
      errors++;
      $display("FAIL reset_mid: rdy=%b vld=%b sum=%h co=%b ov=%b bits=%b%b%b",
               o_ready, o_valid, o_sum, o_cout, o_ovf, bit_a, bit_b, bit_c);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(8'h12, 8'h34, 1'b0, 1'b0, res, lat);
    checks++;
    if (res !== {2'b00, 8'h46}) begin
      errors++;
      $display("FAIL post_reset_op: got %h required %h", res, {2'b00, 8'h46});
    end
    finish_op();
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    logic [W+1:0] res;
    int lat;
    run_op(8'h10, 8'h01, 1'b0, 1'b1, res, lat);
    checks++;
    if (res !== {2'b01, 8'h0F}) begin
      errors++;
      $display("FAIL sub_0: got %h required %h", res, {2'b01, 8'h0F});
    end
    finish_op();
    run_op(8'h80, 8'h01, 1'b1, 1'b1, res, lat);
    checks++;
    if (res !== {2'b11, 8'h7F}) begin
      errors++;
      $display("FAIL sub_1: got %h required %h", res, {2'b11, 8'h7F});
    end
    finish_op();
  endtask
`endif

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic         s;
    logic [W+1:0] res;
    logic [W+1:0] exp;
    int lat;
    for (int i = 0; i < 30; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      c = 1'($urandom);
      s = 1'($urandom);
      exp = model(a, b, c, s);
      run_op(a, b, c, s, res, lat);
      checks++;
      if (res !== exp || lat != 9) begin
        errors++;
        $display("FAIL random_%0d: a=%h b=%h c=%b s=%b got %h lat %0d required %h",
                 i, a, b, c, s, res, lat, exp);
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      finish_op();
    end
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] exp_q[$];
    logic [W+1:0] exp;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int sent;
    int got;
    int last;
    sent = 0;
    got = 0;
    last = -1;
    i_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
      if (o_valid) begin
        exp = exp_q.pop_front();
        checks++;
        if ({o_ovf, o_cout, o_sum} !== exp) begin
          errors++;
          $display("FAIL b2b_result_%0d: got %h required %h",
                   got, {o_ovf, o_cout, o_sum}, exp);
        end
        got++;
      end
      if (o_ready && sent < 4) begin
        a = W'($urandom);
        b = W'($urandom);
        i_a = a;
        i_b = b;
        i_cin = 1'b0;
        i_sub = 1'b0;
        i_valid = 1'b1;
        exp_q.push_back(model(a, b, 1'b0, 1'b0));
        if (last >= 0) begin
          checks++;
          if (cyc - last != W + 3) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d required %0d", cyc - last, W + 3);
          end
        end
        last = cyc;
        sent++;
      end else begin
        i_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    i_ready = 1'b0;
    checks++;
    if (got != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d required 4", got);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
